// File: rtl/fifo_axis_bridge.sv
// Drains an async_fifo read port into an AXI-Stream master through a 3-entry skid
// buffer, framing the stream into PKT_LEN-beat packets and counting accepted beats.
module fifo_axis_bridge #(
  parameter int    DSIZE       = 32,
  parameter string FALLTHROUGH = "TRUE",
  parameter int    PKT_LEN     = 256
) (
  input  logic             rclk,
  input  logic             rrst_n,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic [DSIZE-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [31:0]      beat_total
);
  localparam bit          FT        = (FALLTHROUGH == "TRUE");
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic [DSIZE-1:0] r_buf [3];
  logic [1:0]       r_wptr;
  logic [1:0]       r_rptr;
  logic [1:0]       r_occ;
  logic             r_infl;
  logic [15:0]      r_pcnt;
  logic [31:0]      r_beat_total;
  logic [2:0]       w_pending;
  logic             w_capture;
  logic             w_accept;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Pop depends only on registered occupancy and rempty, so tready never reaches rinc.
  assign w_pending     = {1'b0, r_occ} + {2'b00, r_infl};
  assign rinc          = rrst_n & ~rempty & (w_pending < 3'd3);
  assign w_capture     = FT ? rinc : r_infl;
  assign m_axis_tvalid = (r_occ != 2'd0);
  assign w_accept      = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = r_buf[r_rptr];
  assign m_axis_tlast  = m_axis_tvalid & (r_pcnt == LAST_BEAT);
  assign beat_total    = r_beat_total;

  // NOTE: the buffer is reset like any other register so tdata reads 0 while in reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < 3; i++) r_buf[i] <= '0;
    end else if (w_capture) begin
      r_buf[r_wptr] <= rdata;
    end
  end

  // NOTE: non-blocking assignments make every register here update from pre-edge values.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_wptr       <= 2'd0;
      r_rptr       <= 2'd0;
      r_occ        <= 2'd0;
      r_infl       <= 1'b0;
      r_pcnt       <= 16'd0;
      r_beat_total <= 32'd0;
    end else begin
      r_infl <= FT ? 1'b0 : rinc;
      if (w_capture) r_wptr <= next_ptr(r_wptr);
      if (w_accept) begin
        r_rptr       <= next_ptr(r_rptr);
        r_pcnt       <= (r_pcnt == LAST_BEAT) ? 16'd0 : r_pcnt + 16'd1;
        r_beat_total <= r_beat_total + 32'd1;
      end
      if (w_capture && !w_accept)      r_occ <= r_occ + 2'd1;
      else if (!w_capture && w_accept) r_occ <= r_occ - 2'd1;
    end
  end
endmodule

// File: tb/tb_fifo_axis_bridge.sv
// Drives three bridges (show-ahead/256, registered/16, show-ahead/1) from queue-based
// FIFO models and compares every beat against an in-order stream reference.
module tb_fifo_axis_bridge;
  localparam int          DW = 32;
  localparam int unsigned PKT [3] = '{256, 16, 1};
  localparam int          LAT [3] = '{1, 2, 1};

  logic            rclk   = 1'b0;
  logic            rrst_n = 1'b1;
  logic            tready = 1'b0;
  logic            rinc_v   [3];
  logic            rempty_v [3];
  logic            tvalid_v [3];
  logic            tlast_v  [3];
  logic [DW-1:0]   rdata_v  [3];
  logic [DW-1:0]   tdata_v  [3];
  logic [31:0]     beat_v   [3];

  int              vectors     = 0;
  int              miscompares = 0;
  int              cyc         = 0;
  int              ready_pct   = 100;
  int unsigned     q [3][$];
  int unsigned     exp_next [3];
  int unsigned     popped   [3];
  logic [31:0]     n_acc    [3];
  int              first_rinc [3];
  int              first_valid[3];
  int              first_acc  [3];
  int              last_acc   [3];
  bit              prev_stall [3];
  logic [DW-1:0]   prev_data  [3];
  logic            prev_last  [3];
  bit              do_pop [3];
  bit              do_acc [3];

  fifo_axis_bridge #(.DSIZE(DW), .FALLTHROUGH("TRUE"), .PKT_LEN(256)) dut0 (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc_v[0]), .rdata(rdata_v[0]), .rempty(rempty_v[0]),
    .m_axis_tdata(tdata_v[0]), .m_axis_tvalid(tvalid_v[0]), .m_axis_tready(tready),
    .m_axis_tlast(tlast_v[0]), .beat_total(beat_v[0]));

  fifo_axis_bridge #(.DSIZE(DW), .FALLTHROUGH("FALSE"), .PKT_LEN(16)) dut1 (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc_v[1]), .rdata(rdata_v[1]), .rempty(rempty_v[1]),
    .m_axis_tdata(tdata_v[1]), .m_axis_tvalid(tvalid_v[1]), .m_axis_tready(tready),
    .m_axis_tlast(tlast_v[1]), .beat_total(beat_v[1]));

  fifo_axis_bridge #(.DSIZE(DW), .FALLTHROUGH("TRUE"), .PKT_LEN(1)) dut2 (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc_v[2]), .rdata(rdata_v[2]), .rempty(rempty_v[2]),
    .m_axis_tdata(tdata_v[2]), .m_axis_tvalid(tvalid_v[2]), .m_axis_tready(tready),
    .m_axis_tlast(tlast_v[2]), .beat_total(beat_v[2]));

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  // Show-ahead FIFOs present the head word; registered FIFOs present it after the pop.
  task automatic drive_fifo();
    for (int d = 0; d < 3; d++) begin
      rempty_v[d] = (q[d].size() == 0);
      if (d != 1) rdata_v[d] = (q[d].size() != 0) ? DW'(q[d][0]) : 32'hDEAD_BEEF;
    end
  endtask

  task automatic preload(input int unsigned lo, input int unsigned hi);
    for (int unsigned w = lo; w < hi; w++)
      for (int d = 0; d < 3; d++) q[d].push_back(w);
    drive_fifo();
  endtask

  task automatic do_reset();
    #2 rrst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_rinc",   d, 32'(rinc_v[d]),   32'd0);
      check("rst_tvalid", d, 32'(tvalid_v[d]), 32'd0);
      check("rst_tlast",  d, 32'(tlast_v[d]),  32'd0);
      check("rst_tdata",  d, tdata_v[d],       32'd0);
      check("rst_beats",  d, beat_v[d],        32'd0);
      q[d].delete();
      exp_next[d] = 0; popped[d] = 0; n_acc[d] = 32'd0;
      first_rinc[d] = -1; first_valid[d] = -1; first_acc[d] = -1; last_acc[d] = -1;
      prev_stall[d] = 1'b0;
    end
    rdata_v[1] = 32'hDEAD_BEEF;
    drive_fifo();
    repeat (2) @(posedge rclk);
    #1 rrst_n = 1'b1;
  endtask

  task automatic cycle();
    @(negedge rclk);
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (prev_stall[d]) begin
        check("hold_valid", d, 32'(tvalid_v[d]), 32'd1);
        check("hold_data",  d, tdata_v[d],       prev_data[d]);
        check("hold_last",  d, 32'(tlast_v[d]),  32'(prev_last[d]));
      end
      if (rinc_v[d] && first_rinc[d] < 0) first_rinc[d] = cyc;
      if (tvalid_v[d] && first_valid[d] < 0) begin
        first_valid[d] = cyc;
        check("latency", d, 32'(cyc - first_rinc[d]), 32'(LAT[d]));
      end
      do_pop[d] = rinc_v[d];
      do_acc[d] = tvalid_v[d] & tready;
      if (do_acc[d]) begin
        check("tdata", d, tdata_v[d], exp_next[d]);
        check("tlast", d, 32'(tlast_v[d]), 32'((exp_next[d] % PKT[d]) == PKT[d] - 1));
        if (first_acc[d] < 0) first_acc[d] = cyc;
        last_acc[d] = cyc;
      end
      prev_stall[d] = tvalid_v[d] & ~tready;
      prev_data[d]  = tdata_v[d];
      prev_last[d]  = tlast_v[d];
    end
    tready = ~tready;
    #1;
    for (int d = 0; d < 3; d++) check("rinc_vs_tready", d, 32'(rinc_v[d]), 32'(do_pop[d]));
    tready = ~tready;
    @(posedge rclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (do_acc[d]) begin
        exp_next[d]++;
        n_acc[d] = n_acc[d] + 32'd1;
      end
      check("beat_total", d, beat_v[d], n_acc[d]);
      if (do_pop[d]) begin
        check("pop_nonempty", d, 32'(q[d].size() != 0), 32'd1);
        if (q[d].size() != 0) begin
          int unsigned w;
          w = q[d].pop_front();
          if (d == 1) rdata_v[1] = DW'(w);
          popped[d]++;
        end
      end
      check("occupancy", d, 32'((popped[d] - exp_next[d]) <= 3), 32'd1);
    end
    drive_fifo();
    tready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic run_until(input int unsigned n, input int budget);
    int b = 0;
    while ((exp_next[0] < n || exp_next[1] < n || exp_next[2] < n) && b < budget) begin
      cycle();
      b++;
    end
    for (int d = 0; d < 3; d++) check("beat_count", d, exp_next[d], n);
  endtask

  initial begin
    rdata_v[1] = 32'hDEAD_BEEF;
    do_reset();

    // Fill/drain with tready held high: in-order data, tlast framing, no gaps.
    ready_pct = 100;
    tready    = 1'b1;
    preload(0, 4096);
    run_until(4096, 4400);
    for (int d = 0; d < 3; d++) begin
      check("final_beats", d, beat_v[d], 32'd4096);
      check("no_gap", d, 32'(last_acc[d] - first_acc[d]), 32'd4095);
    end

    // Random backpressure at 30 % ready.
    do_reset();
    ready_pct = 30;
    tready    = ($urandom_range(99) < ready_pct);
    preload(0, 1000);
    run_until(1000, 6000);

    // Stall on empty between two 10-word bursts.
    do_reset();
    ready_pct = 100;
    tready    = 1'b1;
    preload(0, 10);
    repeat (20) cycle();
    for (int d = 0; d < 3; d++) check("gap_tvalid", d, 32'(tvalid_v[d]), 32'd0);
    repeat (30) cycle();
    preload(10, 20);
    run_until(20, 60);
    check("pcnt_end", 1, 32'(dut1.r_pcnt), 32'd4);

    // Reset mid-packet with every buffer full.
    do_reset();
    ready_pct = 100;
    tready    = 1'b1;
    preload(0, 300);
    for (int b = 0; b < 300 && exp_next[0] < 100; b++) cycle();
    tready    = 1'b0;
    ready_pct = 0;
    repeat (6) cycle();
    for (int d = 0; d < 3; d++) check("buffer_full", d, popped[d] - exp_next[d], 32'd3);
    check("pcnt_100", 0, 32'(dut0.r_pcnt), 32'd100);
    do_reset();
    ready_pct = 100;
    tready    = 1'b1;
    preload(0, 40);
    run_until(40, 100);

    // Beat counter wrap on the single-beat-packet instance.
    do_reset();
    ready_pct = 0;
    tready    = 1'b0;
    preload(0, 5);
    repeat (4) cycle();
    force dut2.r_beat_total = 32'hFFFF_FFFF;
    #1;
    release dut2.r_beat_total;
    n_acc[2] = 32'hFFFF_FFFF;
    tready   = 1'b1;
    cycle();
    check("wrap", 2, beat_v[2], 32'd0);
    ready_pct = 100;
    tready    = 1'b1;
    run_until(5, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
